// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: opcode[6:2] encodings, forwarding-select codes
// and operand-usage decode helpers.
package riscv_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_e;

    // U-type and JAL carry immediate bits in the rs1 field, so it must not create hazards.
    function automatic logic rs1_used(input logic [4:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic rs2_used(input logic [4:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Per-operand Execute forwarding select: M-stage result wins over W-stage, x0 never forwards.
module fwd_match
    import riscv_pkg::*;
(
    input  logic       m_valid_i,
    input  logic [4:0] m_rd_i,
    input  logic       w_valid_i,
    input  logic [4:0] w_rd_i,
    input  logic [4:0] rs_i,
    output logic [1:0] sel_o
);

    logic m_hit;
    logic w_hit;

    assign m_hit = m_valid_i && (m_rd_i != 5'd0) && (m_rd_i == rs_i);
    assign w_hit = w_valid_i && (w_rd_i != 5'd0) && (w_rd_i == rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (m_hit) begin
            sel_o = FWD_M;
        end else if (w_hit) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, branch flush, ecall halt, Execute forwarding
// selects and Decode register-file bypass, driven by a shadow copy of the M/W stages.
module hazard_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] d_rs1_index,
    input  logic [4:0] d_rs2_index,
    input  logic [4:0] d_opcode,
    input  logic [4:0] e_rs1_index,
    input  logic [4:0] e_rs2_index,
    input  logic [4:0] e_rd_index,
    input  logic [4:0] e_opcode,
    input  logic       e_wb_en,
    input  logic       e_ecall,
    input  logic       e_jb_taken,
    output logic       stall,
    output logic       flush_fd,
    output logic       flush_de,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel,
    output logic       byp_rs1,
    output logic       byp_rs2,
    output logic       halted
);

    logic [4:0] m_rd_q, m_rd_d;
    logic       m_wb_en_q, m_wb_en_d;
    logic       m_is_load_q, m_is_load_d;
    logic [4:0] w_rd_q, w_rd_d;
    logic       w_wb_en_q, w_wb_en_d;
    logic       halted_q, halted_d;

    logic       load_use;
    logic       rs1_hit;
    logic       rs2_hit;

    always_comb begin
        m_rd_d      = e_rd_index;
        m_wb_en_d   = e_wb_en;
        m_is_load_d = (e_opcode == OPC_LOAD);
        w_rd_d      = m_rd_q;
        w_wb_en_d   = m_wb_en_q;
        // A redirect in the same cycle squashes the ecall, so it never halts.
        halted_d    = halted_q | (e_ecall & ~e_jb_taken);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rd_q      <= 5'd0;
            m_wb_en_q   <= 1'b0;
            m_is_load_q <= 1'b0;
            w_rd_q      <= 5'd0;
            w_wb_en_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            m_rd_q      <= m_rd_d;
            m_wb_en_q   <= m_wb_en_d;
            m_is_load_q <= m_is_load_d;
            w_rd_q      <= w_rd_d;
            w_wb_en_q   <= w_wb_en_d;
            halted_q    <= halted_d;
        end
    end

    assign rs1_hit  = rs1_used(d_opcode) && (e_rd_index == d_rs1_index);
    assign rs2_hit  = rs2_used(d_opcode) && (e_rd_index == d_rs2_index);
    assign load_use = (e_opcode == OPC_LOAD) && e_wb_en && (e_rd_index != 5'd0)
                      && (rs1_hit || rs2_hit);

    // Priority: reset, then halt, then redirect, then load-use bubble.
    always_comb begin
        stall    = 1'b0;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        if (!rst) begin
            stall    = 1'b0;
        end else if (halted_q) begin
            stall    = 1'b1;
            flush_de = 1'b1;
        end else if (e_jb_taken) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
        end else if (load_use) begin
            stall    = 1'b1;
            flush_de = 1'b1;
        end
    end

    // A load in M has no data yet; it is only forwardable once it reaches W.
    fwd_match u_fwd_rs1 (
        .m_valid_i (m_wb_en_q & ~m_is_load_q),
        .m_rd_i    (m_rd_q),
        .w_valid_i (w_wb_en_q),
        .w_rd_i    (w_rd_q),
        .rs_i      (e_rs1_index),
        .sel_o     (fwd_rs1_sel)
    );

    fwd_match u_fwd_rs2 (
        .m_valid_i (m_wb_en_q & ~m_is_load_q),
        .m_rd_i    (m_rd_q),
        .w_valid_i (w_wb_en_q),
        .w_rd_i    (w_rd_q),
        .rs_i      (e_rs2_index),
        .sel_o     (fwd_rs2_sel)
    );

    assign byp_rs1 = w_wb_en_q && (w_rd_q != 5'd0) && (w_rd_q == d_rs1_index);
    assign byp_rs2 = w_wb_en_q && (w_rd_q != 5'd0) && (w_rd_q == d_rs2_index);
    assign halted  = halted_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a queue-based reference model.
module tb_hazard_ctrl;
    import riscv_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] d_rs1_index, d_rs2_index, d_opcode;
    logic [4:0] e_rs1_index, e_rs2_index, e_rd_index, e_opcode;
    logic       e_wb_en, e_ecall, e_jb_taken;
    logic       stall, flush_fd, flush_de, byp_rs1, byp_rs2, halted;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .d_rs1_index (d_rs1_index),
        .d_rs2_index (d_rs2_index),
        .d_opcode    (d_opcode),
        .e_rs1_index (e_rs1_index),
        .e_rs2_index (e_rs2_index),
        .e_rd_index  (e_rd_index),
        .e_opcode    (e_opcode),
        .e_wb_en     (e_wb_en),
        .e_ecall     (e_ecall),
        .e_jb_taken  (e_jb_taken),
        .stall       (stall),
        .flush_fd    (flush_fd),
        .flush_de    (flush_de),
        .fwd_rs1_sel (fwd_rs1_sel),
        .fwd_rs2_sel (fwd_rs2_sel),
        .byp_rs1     (byp_rs1),
        .byp_rs2     (byp_rs2),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: instructions that left Execute, newest first (index 0 = M, 1 = W).
    typedef struct packed {
        logic [4:0] rd;
        logic       wb;
        logic       ld;
    } retired_t;

    retired_t   hist[$];
    logic       halted_m;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] ops[10];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        retired_t z;
        z = '0;
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
        halted_m = 1'b0;
    endtask

    task automatic set_e(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wb, input logic ec, input logic jb);
        e_opcode = op; e_rs1_index = rs1; e_rs2_index = rs2; e_rd_index = rd;
        e_wb_en = wb; e_ecall = ec; e_jb_taken = jb;
    endtask

    task automatic set_d(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
        d_opcode = op; d_rs1_index = rs1; d_rs2_index = rs2;
    endtask

    task automatic bubble_e();
        set_e(OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        retired_t cur;
        cur.rd = e_rd_index;
        cur.wb = e_wb_en;
        cur.ld = (e_opcode == OPC_LOAD);
        @(posedge clk);
        if (rst) begin
            hist.push_front(cur);
            void'(hist.pop_back());
            if (e_ecall && !e_jb_taken) halted_m = 1'b1;
        end
        #1;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (hist[0].wb && !hist[0].ld && hist[0].rd != 0 && hist[0].rd == rs) return 2'd1;
        if (hist[1].wb && hist[1].rd != 0 && hist[1].rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic exp_byp(input logic [4:0] rs);
        return hist[1].wb && hist[1].rd != 0 && hist[1].rd == rs;
    endfunction

    task automatic check_all(input string tag);
        logic u1, u2, lu, es, eff, efd;
        u1 = !(d_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        u2 = d_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        lu = (e_opcode == OPC_LOAD) && e_wb_en && (e_rd_index != 0) &&
             ((u1 && e_rd_index == d_rs1_index) || (u2 && e_rd_index == d_rs2_index));
        {es, eff, efd} = 3'b000;
        if (!rst)              {es, eff, efd} = 3'b000;
        else if (halted_m)     {es, eff, efd} = 3'b101;
        else if (e_jb_taken)   {es, eff, efd} = 3'b011;
        else if (lu)           {es, eff, efd} = 3'b101;
        chk({tag, "_stall"},    8'(stall),       8'(es));
        chk({tag, "_flush_fd"}, 8'(flush_fd),    8'(eff));
        chk({tag, "_flush_de"}, 8'(flush_de),    8'(efd));
        chk({tag, "_fwd1"},     8'(fwd_rs1_sel), 8'(exp_fwd(e_rs1_index)));
        chk({tag, "_fwd2"},     8'(fwd_rs2_sel), 8'(exp_fwd(e_rs2_index)));
        chk({tag, "_byp1"},     8'(byp_rs1),     8'(exp_byp(d_rs1_index)));
        chk({tag, "_byp2"},     8'(byp_rs2),     8'(exp_byp(d_rs2_index)));
        chk({tag, "_halted"},   8'(halted),      8'(halted_m));
    endtask

    int halt_cnt;

    initial begin
        ops = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
        rst = 1'b0;
        set_e(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_d(5'd0, 5'd0, 5'd0);
        model_reset();

        // Reset: all inputs zero, every output zero.
        #12;
        chk("rst_stall", 8'(stall), 8'd0);
        chk("rst_ffd", 8'(flush_fd), 8'd0);
        chk("rst_fde", 8'(flush_de), 8'd0);
        chk("rst_fwd", 8'({fwd_rs1_sel, fwd_rs2_sel}), 8'd0);
        chk("rst_byp", 8'({byp_rs1, byp_rs2}), 8'd0);
        chk("rst_halt", 8'(halted), 8'd0);
        rst = 1'b1;
        tick();

        // Load-use: one bubble, then the consumer reads the load result from W.
        set_e(OPC_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        set_d(OPC_OP, 5'd1, 5'd5);
        #1;
        chk("lu_stall", 8'(stall), 8'd1);
        chk("lu_fde", 8'(flush_de), 8'd1);
        chk("lu_ffd", 8'(flush_fd), 8'd0);
        tick();
        bubble_e();
        #1;
        chk("lu_stall_next", 8'(stall), 8'd0);
        chk("lu_fde_next", 8'(flush_de), 8'd0);
        tick();
        set_e(OPC_OP, 5'd1, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
        set_d(OPC_OP_IMM, 5'd0, 5'd0);
        #1;
        chk("lu_fwd2_w", 8'(fwd_rs2_sel), 8'd2);
        tick();

        // No false stall: LUI's rs1/rs2 fields are immediate bits.
        set_e(OPC_LOAD, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        set_d(OPC_LUI, 5'd5, 5'd5);
        #1;
        chk("lui_no_stall", 8'(stall), 8'd0);
        set_d(OPC_OP_IMM, 5'd0, 5'd5);
        #1;
        chk("opimm_rs2_unused", 8'(stall), 8'd0);
        tick();

        // Forwarding priority: two ALU writes of x7, reader sees M.
        set_e(OPC_OP, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_e(OPC_OP, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_e(OPC_OP, 5'd7, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fwd_m_prio", 8'(fwd_rs1_sel), 8'd1);
        tick();
        set_e(OPC_OP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_e(OPC_OP, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_e(OPC_OP, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fwd_x0", 8'(fwd_rs1_sel), 8'd0);
        tick();
        // Load in M is not forwardable; the older W write of x7 is used.
        set_e(OPC_OP, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_e(OPC_LOAD, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_e(OPC_OP, 5'd7, 5'd7, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fwd_load_in_m", 8'({fwd_rs1_sel, fwd_rs2_sel}), 8'b1010);
        tick();

        // Jump overrides load-use.
        set_e(OPC_LOAD, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        set_d(OPC_OP, 5'd5, 5'd0);
        #1;
        chk("jb_ffd", 8'(flush_fd), 8'd1);
        chk("jb_fde", 8'(flush_de), 8'd1);
        chk("jb_stall", 8'(stall), 8'd0);
        tick();

        // W bypass into Decode.
        set_d(OPC_OP_IMM, 5'd0, 5'd0);
        set_e(OPC_OP, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        bubble_e();
        tick();
        set_d(OPC_OP_IMM, 5'd3, 5'd0);
        #1;
        chk("byp_w", 8'(byp_rs1), 8'd1);
        set_e(OPC_OP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        bubble_e();
        tick();
        #1;
        chk("byp_w_nowb", 8'(byp_rs1), 8'd0);

        // ecall together with a taken branch: flush wins, no halt.
        set_e(OPC_SYSTEM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("ecall_jb_ffd", 8'(flush_fd), 8'd1);
        tick();
        bubble_e();
        #1;
        chk("ecall_jb_nohalt", 8'(halted), 8'd0);

        // ecall halts on the following edge and stays halted.
        set_e(OPC_SYSTEM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("ecall_pre", 8'(halted), 8'd0);
        tick();
        bubble_e();
        #1;
        chk("halt_set", 8'(halted), 8'd1);
        chk("halt_ctrl", 8'({stall, flush_fd, flush_de}), 8'b101);
        set_e(OPC_JAL, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("halt_ign_jb", 8'({stall, flush_fd, flush_de}), 8'b101);
        tick();
        #1;
        chk("halt_sticky", 8'(halted), 8'd1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("halt_rst_halted", 8'(halted), 8'd0);
        chk("halt_rst_ctrl", 8'({stall, flush_fd, flush_de}), 8'b000);
        rst = 1'b1;
        tick();

        // Reset during a load-use stall drops stall/flush immediately.
        set_e(OPC_LOAD, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        set_d(OPC_STORE, 5'd0, 5'd6);
        #1;
        chk("stall_pre_rst", 8'(stall), 8'd1);
        rst = 1'b0;
        #1;
        chk("stall_rst", 8'({stall, flush_de}), 8'd0);
        model_reset();
        rst = 1'b1;
        tick();

        // Randomized traffic against the reference model.
        halt_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            set_e(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) == 0));
            set_d(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            check_all("rnd");
            tick();
            if (halted_m) halt_cnt++;
            if (halt_cnt > 3) begin
                rst = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                rst = 1'b1;
                halt_cnt = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single rising-edge clock for all state.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset; all state clears while rst=0.
REQ-003 The module SHALL have ports d_rs1_index and d_rs2_index, input, 5 bits each: source register indices of the instruction in Decode.
REQ-004 The module SHALL have port d_opcode, input, 5 bits: opcode[6:2] of the instruction in Decode.
REQ-005 The module SHALL have ports e_rs1_index, e_rs2_index and e_rd_index, input, 5 bits each: indices taken from the D/E pipeline register outputs.
REQ-006 The module SHALL have ports e_opcode (input, 5 bits), e_wb_en (input, 1 bit) and e_ecall (input, 1 bit): Execute-stage control signals from the D/E pipeline register.
REQ-007 The module SHALL have port e_jb_taken, input, 1 bit: the branch or jump in Execute redirects the PC this cycle.
REQ-008 The module SHALL have port stall, output, 1 bit: holds the PC and the F/D register.
REQ-009 The module SHALL have ports flush_fd and flush_de, output, 1 bit each: bubble into the F/D register and the D/E register respectively.
REQ-010 The module SHALL have ports fwd_rs1_sel and fwd_rs2_sel, output, 2 bits each: Execute operand source, 0=register file, 1=M stage, 2=W stage.
REQ-011 The module SHALL have ports byp_rs1 and byp_rs2, output, 1 bit each: the Decode read takes the W-stage write data.
REQ-012 The module SHALL have port halted, output, 1 bit: sticky halt after an ecall.
REQ-013 The module SHALL use these opcode constants: LOAD=00000, OP_IMM=00100, AUIPC=00101, STORE=01000, OP=01100, LUI=01101, BRANCH=11000, JALR=11001, JAL=11011, SYSTEM=11100.

Function
REQ-014 The module SHALL keep a shadow pipeline, updated every clock edge: M registers (m_rd, m_wb_en, m_is_load) load the E inputs, and W registers (w_rd, w_wb_en) load the M registers.
REQ-015 The rs1 operand SHALL count as used for every opcode except LUI, AUIPC and JAL.
REQ-016 The rs2 operand SHALL count as used only for OP, STORE and BRANCH.
REQ-017 The load-use condition SHALL be true when e_opcode=LOAD, e_wb_en=1, e_rd_index!=0, and e_rd_index equals a used Decode source.
REQ-018 When the load-use condition is true, stall and flush_de SHALL be 1 combinationally in the same cycle, giving exactly one bubble.
REQ-019 The load-use condition SHALL clear on the next cycle without any extra state.
REQ-020 When e_jb_taken=1, flush_fd and flush_de SHALL be 1 and stall SHALL be 0; a taken jump or branch overrides the load-use stall.
REQ-021 fwd_rsX_sel SHALL be 1 when m_wb_en=1, m_is_load=0, m_rd!=0 and m_rd=e_rsX_index.
REQ-022 Otherwise, fwd_rsX_sel SHALL be 2 when w_wb_en=1, w_rd!=0 and w_rd=e_rsX_index; otherwise it SHALL be 0; M has priority over W.
REQ-023 byp_rsX SHALL be 1 when w_wb_en=1, w_rd!=0 and w_rd=d_rsX_index; writes to x0 never forward or bypass.
REQ-024 The halted register SHALL set on the clock edge where e_ecall=1 and e_jb_taken=0, and SHALL stay set until reset.
REQ-025 While halted=1, stall=1, flush_fd=0, flush_de=1, and e_jb_taken SHALL be ignored.
REQ-026 When e_ecall=1 and e_jb_taken=1 occur together, the flush SHALL win and halted SHALL stay 0.

Reset
REQ-027 While rst=0, all shadow registers and halted SHALL be 0 regardless of the clock.
REQ-028 In reset, with all inputs at 0, every output SHALL be 0.
REQ-029 When reset asserts mid-stall or mid-halt, stall, flush_de and halted SHALL drop immediately.

Structure
REQ-030 The opcode constants and the fwd_sel encodings SHALL live in the shared package riscv_pkg.
REQ-031 A single sub-module fwd_match SHALL compute one operand's selection (instantiated twice) from valid, rd and rs comparisons; no other sub-modules SHALL be used.

Verification
REQ-032 The bench SHALL check load-use: E: LOAD, rd=5, wb_en=1; D: OP with rs2=5 -> stall=1, flush_de=1 for one cycle; two cycles later fwd_rs2_sel=2.
REQ-033 The bench SHALL check no false stall: E: LOAD rd=5; D: LUI (rs1 field=5) -> stall=0.
REQ-034 The bench SHALL check forwarding priority: the ALU writes x7 in two consecutive instructions, then a reader of x7 enters E -> fwd_rs1_sel=1; with rd=0 in place of x7 -> fwd_rs1_sel=0.
REQ-035 The bench SHALL check the jump override: e_jb_taken=1 together with the load-use condition -> flush_fd=1, flush_de=1, stall=0.
REQ-036 The bench SHALL check ecall: e_ecall=1 -> next cycle halted=1, stall=1; e_jb_taken=1 later has no effect; rst=0 -> halted=0 immediately.
REQ-037 The bench SHALL check the W bypass: W writes x3 with wb_en=1 while D reads rs1=3 -> byp_rs1=1; with wb_en=0 -> byp_rs1=0.
